// File: rtl/l2cache_pkg.sv
// Shared types and helpers for the N-way L2 controller: FSM states,
// lowest-set-bit search and tree-PLRU victim/update functions.
package l2cache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2
  } state_t;

  localparam int MAX_WAYS = 64;

  function automatic logic [5:0] first_set_idx(input logic [MAX_WAYS-1:0] vec);
    logic [5:0] idx;
    idx = 6'd0;
    for (int i = MAX_WAYS - 1; i >= 0; i--) begin
      if (vec[i[5:0]]) idx = i[5:0];
    end
    return idx;
  endfunction

  // Heap-ordered tree: node n has children 2n+1 (left) and 2n+2 (right).
  function automatic logic [5:0] plru_victim(input logic [MAX_WAYS-2:0] bits, input int lvls);
    logic [5:0] node;
    logic [5:0] way;
    logic       b;
    node = 6'd0;
    way  = 6'd0;
    for (int lvl = 0; lvl < lvls; lvl++) begin
      b    = bits[node];
      way  = {way[4:0], b};
      node = (node << 1) + 6'd1 + {5'd0, b};
    end
    return way;
  endfunction

  function automatic logic [MAX_WAYS-2:0] plru_update(input logic [MAX_WAYS-2:0] bits,
                                                      input logic [5:0] way, input int lvls);
    logic [MAX_WAYS-2:0] res;
    logic [5:0]          node;
    logic                d;
    res  = bits;
    node = 6'd0;
    for (int lvl = 0; lvl < lvls; lvl++) begin
      d         = |(way & (6'd1 << (lvls - 1 - lvl)));
      res[node] = ~d;
      node      = (node << 1) + 6'd1 + {5'd0, d};
    end
    return res;
  endfunction

endpackage

// File: rtl/l2_plru.sv
// Per-set tree-PLRU state (SETS x WAYS-1 bits); combinational victim read,
// single-port update pointing every node on the accessed path away from it.
module l2_plru
  import l2cache_pkg::*;
#(
  parameter  int WAYS  = 4,
  parameter  int SETS  = 32,
  localparam int IDX_W = $clog2(SETS),
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_set,
  output logic [WAY_W-1:0] victim,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_set,
  input  logic [WAY_W-1:0] upd_way
);

  logic [WAYS-2:0] plru_r [SETS];

  // Tree bit storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) plru_r[s] <= '0;
    end else if (upd_en) begin
      plru_r[upd_set] <= (WAYS-1)'(plru_update((MAX_WAYS-1)'(plru_r[upd_set]),
                                               6'(upd_way), WAY_W));
    end
  end

  assign victim = WAY_W'(plru_victim((MAX_WAYS-1)'(plru_r[rd_set]), WAY_W));

endmodule

// File: rtl/l2cache_ctrl_nway_chk.sv
// Protocol checks for the L2 controller: at most one way may hit per request.
module l2cache_ctrl_nway_chk #(
  parameter int WAYS = 4
) (
  input logic            clk,
  input logic            rst,
  input logic            idle,
  input logic            req,
  input logic [WAYS-1:0] hit_vec
);

  a_single_hit: assert property (@(posedge clk) disable iff (rst)
    (idle && req) |-> $onehot0(hit_vec));

endmodule

// File: rtl/l2cache_ctrl_nway.sv
// N-way write-back L2 control FSM (IDLE/WB/FILL) with invalid-first victim choice.
// Optional saturating hit/miss/write-back counters under L2_PERF_CNT_EN.
module l2cache_ctrl_nway
  import l2cache_pkg::*;
#(
  parameter  int WAYS  = 4,
  parameter  int SETS  = 32,
  localparam int IDX_W = $clog2(SETS),
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [IDX_W-1:0] mem_set,
  input  logic [WAYS-1:0]  hit_vec,
  input  logic [WAYS-1:0]  valid_vec,
  input  logic [WAYS-1:0]  dirty_vec,
  input  logic             pmem_resp,
  output logic             mem_resp,
  output logic             pmem_read,
  output logic             pmem_write,
  output logic             pmem_addr_sel,
  output logic [WAY_W-1:0] way_sel,
  output logic             load_tag,
  output logic             load_data,
  output logic             load_valid,
  output logic             data_in_sel,
  output logic             set_dirty,
  output logic             clr_dirty,
  output logic             busy
`ifdef L2_PERF_CNT_EN
  ,
  output logic [31:0]      hit_cnt,
  output logic [31:0]      miss_cnt,
  output logic [31:0]      wb_cnt
`endif
);

  state_t           state_r;
  logic [WAY_W-1:0] victim_r;
  logic [IDX_W-1:0] set_r;

  logic             req_s;
  logic             hit_any_s;
  logic             miss_s;
  logic             need_wb_s;
  logic [WAYS-1:0]  inv_vec_s;
  logic [WAY_W-1:0] hit_idx_s;
  logic [WAY_W-1:0] inv_idx_s;
  logic [WAY_W-1:0] plru_victim_s;
  logic [WAY_W-1:0] miss_victim_s;
  logic             upd_en_s;
  logic [IDX_W-1:0] upd_set_s;
  logic [WAY_W-1:0] upd_way_s;

  assign req_s         = mem_read | mem_write;
  assign hit_any_s     = |hit_vec;
  assign inv_vec_s     = ~valid_vec;
  assign hit_idx_s     = WAY_W'(first_set_idx(64'(hit_vec)));
  assign inv_idx_s     = WAY_W'(first_set_idx(64'(inv_vec_s)));
  assign miss_victim_s = (&valid_vec) ? plru_victim_s : inv_idx_s;
  assign need_wb_s     = dirty_vec[miss_victim_s] & valid_vec[miss_victim_s];
  assign miss_s        = (state_r == IDLE) && req_s && !hit_any_s;

  l2_plru #(.WAYS(WAYS), .SETS(SETS)) u_plru (
    .clk     (clk),
    .rst     (rst),
    .rd_set  (mem_set),
    .victim  (plru_victim_s),
    .upd_en  (upd_en_s),
    .upd_set (upd_set_s),
    .upd_way (upd_way_s)
  );

  // State, latched victim way and latched miss set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      victim_r <= '0;
      set_r    <= '0;
    end else begin
      case (state_r)
        IDLE: if (miss_s) begin
          victim_r <= miss_victim_s;
          set_r    <= mem_set;
          state_r  <= need_wb_s ? WB : FILL;
        end
        WB:      if (pmem_resp) state_r <= FILL;
        FILL:    if (pmem_resp) state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  // Output decode; the hit response must be visible in the request cycle
  always_comb begin
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr_sel = 1'b1;
    way_sel       = '0;
    load_tag      = 1'b0;
    load_data     = 1'b0;
    load_valid    = 1'b0;
    data_in_sel   = 1'b0;
    set_dirty     = 1'b0;
    clr_dirty     = 1'b0;
    busy          = 1'b0;
    upd_en_s      = 1'b0;
    upd_set_s     = mem_set;
    upd_way_s     = hit_idx_s;
    case (state_r)
      IDLE: begin
        if (req_s && hit_any_s) begin
          mem_resp    = 1'b1;
          way_sel     = hit_idx_s;
          upd_en_s    = 1'b1;
          load_data   = mem_write;
          data_in_sel = mem_write;
          set_dirty   = mem_write;
        end else begin
          way_sel = '0;
        end
      end
      WB: begin
        busy       = 1'b1;
        pmem_write = 1'b1;
        way_sel    = victim_r;
        clr_dirty  = pmem_resp;
      end
      FILL: begin
        busy          = 1'b1;
        pmem_read     = 1'b1;
        pmem_addr_sel = 1'b0;
        way_sel       = victim_r;
        load_tag      = pmem_resp;
        load_data     = pmem_resp;
        load_valid    = pmem_resp;
        clr_dirty     = pmem_resp;
        upd_en_s      = pmem_resp;
        upd_set_s     = set_r;
        upd_way_s     = victim_r;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

`ifdef L2_PERF_CNT_EN
  // Saturating event counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= 32'd0;
      miss_cnt <= 32'd0;
      wb_cnt   <= 32'd0;
    end else begin
      if (state_r == IDLE && req_s && hit_any_s && hit_cnt != 32'hFFFF_FFFF)
        hit_cnt <= hit_cnt + 32'd1;
      if (miss_s && miss_cnt != 32'hFFFF_FFFF)
        miss_cnt <= miss_cnt + 32'd1;
      if (miss_s && need_wb_s && wb_cnt != 32'hFFFF_FFFF)
        wb_cnt <= wb_cnt + 32'd1;
    end
  end
`endif

  l2cache_ctrl_nway_chk #(.WAYS(WAYS)) u_chk (
    .clk     (clk),
    .rst     (rst),
    .idle    (state_r == IDLE),
    .req     (req_s),
    .hit_vec (hit_vec)
  );

endmodule

// File: tb/tb_l2cache_ctrl_nway.sv
// Self-checking bench for l2cache_ctrl_nway. The bench acts as the datapath
// (tag/valid/dirty store) and predicts PLRU victims from per-way access times.
module tb_l2cache_ctrl_nway;

  localparam int WAYS  = 4;
  localparam int SETS  = 32;
  localparam int IDX_W = 5;
  localparam int WAY_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             mem_read, mem_write, pmem_resp;
  logic [IDX_W-1:0] mem_set;
  logic [WAYS-1:0]  hit_vec, valid_vec, dirty_vec;
  logic             mem_resp, pmem_read, pmem_write, pmem_addr_sel;
  logic [WAY_W-1:0] way_sel;
  logic             load_tag, load_data, load_valid, data_in_sel, set_dirty, clr_dirty, busy;
`ifdef L2_PERF_CNT_EN
  logic [31:0]      hit_cnt, miss_cnt, wb_cnt;
`endif

  always #5 clk = ~clk;

  l2cache_ctrl_nway #(.WAYS(WAYS), .SETS(SETS)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .mem_set(mem_set),
    .hit_vec(hit_vec), .valid_vec(valid_vec), .dirty_vec(dirty_vec), .pmem_resp(pmem_resp),
    .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_addr_sel(pmem_addr_sel), .way_sel(way_sel), .load_tag(load_tag),
    .load_data(load_data), .load_valid(load_valid), .data_in_sel(data_in_sel),
    .set_dirty(set_dirty), .clr_dirty(clr_dirty), .busy(busy)
`ifdef L2_PERF_CNT_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
`endif
  );

  int tag_m   [SETS][WAYS];
  bit valid_m [SETS][WAYS];
  bit dirty_m [SETS][WAYS];
  int ts_m    [SETS][WAYS];
  int now_m, hits_m, misses_m, wbs_m;
  int checks = 0;
  int failures = 0;

  function automatic int find_hit(int s, int tg);
    for (int w = 0; w < WAYS; w++) if (valid_m[s][w] && tag_m[s][w] == tg) return w;
    return -1;
  endfunction

  // Tree-PLRU seen as "at each split, evict from the half touched less recently".
  function automatic int model_victim(int s);
    int lo, hi, mid, ml, mr;
    lo = 0; hi = WAYS;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2; ml = 0; mr = 0;
      for (int w = lo; w < mid; w++) if (ts_m[s][w] > ml) ml = ts_m[s][w];
      for (int w = mid; w < hi; w++) if (ts_m[s][w] > mr) mr = ts_m[s][w];
      if (ml > mr) lo = mid; else hi = mid;
    end
    return lo;
  endfunction

  function automatic int pick_victim(int s);
    for (int w = 0; w < WAYS; w++) if (!valid_m[s][w]) return w;
    return model_victim(s);
  endfunction

  task automatic touch(int s, int w);
    now_m++;
    ts_m[s][w] = now_m;
  endtask

  task automatic drive_vecs(int s, int tg);
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w]   = valid_m[s][w] && tag_m[s][w] == tg;
      valid_vec[w] = valid_m[s][w];
      dirty_vec[w] = dirty_m[s][w];
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) for (int w = 0; w < WAYS; w++) ts_m[s][w] = 0;
    now_m = 0; hits_m = 0; misses_m = 0; wbs_m = 0;
  endtask

  task automatic idle();
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0; hit_vec = '0; pmem_resp = 1'b0;
  endtask

  task automatic run_phase(input bit is_wb, input int v, input int lat, input bit drop);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (drop) begin mem_read = 1'b0; mem_write = 1'b0; end
      pmem_resp = (c == lat);
      #1;
      checks++;
      if (busy !== 1'b1 || pmem_write !== is_wb || pmem_read !== !is_wb || mem_resp !== 1'b0) begin
        failures++;
        $display("FAIL phase_strobes wb=%0d got busy=%b pw=%b pr=%b resp=%b", is_wb, busy, pmem_write, pmem_read, mem_resp);
      end
      checks++;
      if (way_sel !== WAY_W'(v) || pmem_addr_sel !== is_wb) begin
        failures++;
        $display("FAIL phase_way got way=%0d asel=%b exp way=%0d asel=%b", way_sel, pmem_addr_sel, v, is_wb);
      end
      checks++;
      if (clr_dirty !== (c == lat) || load_valid !== (!is_wb && c == lat) ||
          load_tag !== (!is_wb && c == lat) || (!is_wb && data_in_sel !== 1'b0)) begin
        failures++;
        $display("FAIL phase_load wb=%0d cyc=%0d got clr=%b lv=%b lt=%b dis=%b", is_wb, c, clr_dirty, load_valid, load_tag, data_in_sel);
      end
      @(posedge clk);
      #1 pmem_resp = 1'b0;
    end
  endtask

  // One upstream access; a miss runs WB/FILL and then the re-hit cycle.
  task automatic do_access(input int s, input int tg, input bit wr, input int lat_wb,
                           input int lat_fill, input bit drop, output int vict);
    int h, v;
    bit wb;
    h = find_hit(s, tg);
    @(negedge clk);
    mem_read = !wr; mem_write = wr; mem_set = IDX_W'(s); pmem_resp = 1'b0;
    drive_vecs(s, tg);
    #1;
    if (h < 0) begin
      v  = pick_victim(s);
      wb = valid_m[s][v] && dirty_m[s][v];
      checks++;
      if (mem_resp !== 1'b0 || busy !== 1'b0 || pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
        failures++;
        $display("FAIL miss_cycle got resp=%b busy=%b pr=%b pw=%b exp all 0", mem_resp, busy, pmem_read, pmem_write);
      end
      @(posedge clk);
      misses_m++;
      if (wb) begin
        wbs_m++;
        run_phase(1'b1, v, lat_wb, drop);
        dirty_m[s][v] = 1'b0;
      end
      run_phase(1'b0, v, lat_fill, drop);
      tag_m[s][v] = tg; valid_m[s][v] = 1'b1; dirty_m[s][v] = 1'b0;
      touch(s, v);
      vict = v;
      if (drop) begin
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || pmem_read !== 1'b0 || mem_resp !== 1'b0) begin
          failures++;
          $display("FAIL drop_done got busy=%b pr=%b resp=%b exp 0", busy, pmem_read, mem_resp);
        end
        return;
      end
      @(negedge clk);
      drive_vecs(s, tg);
      #1;
      h = find_hit(s, tg);
    end else begin
      vict = h;
    end
    checks++;
    if (mem_resp !== 1'b1 || busy !== 1'b0 || pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
      failures++;
      $display("FAIL hit_resp got resp=%b busy=%b pr=%b pw=%b exp 1 0 0 0", mem_resp, busy, pmem_read, pmem_write);
    end
    checks++;
    if (way_sel !== WAY_W'(h)) begin
      failures++;
      $display("FAIL hit_way got %0d exp %0d", way_sel, h);
    end
    checks++;
    if (set_dirty !== wr || load_data !== wr || data_in_sel !== wr || load_tag !== 1'b0 || load_valid !== 1'b0) begin
      failures++;
      $display("FAIL hit_write got sd=%b ld=%b dis=%b lt=%b lv=%b exp wr=%b", set_dirty, load_data, data_in_sel, load_tag, load_valid, wr);
    end
    @(posedge clk);
    hits_m++;
    touch(s, h);
    if (wr) dirty_m[s][h] = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (mem_resp !== 1'b0 || pmem_read !== 1'b0 || pmem_write !== 1'b0 || busy !== 1'b0 ||
        way_sel !== 2'd0 || pmem_addr_sel !== 1'b1) begin
      failures++;
      $display("FAIL reset_out got resp=%b pr=%b pw=%b busy=%b way=%0d asel=%b", mem_resp, pmem_read, pmem_write, busy, way_sel, pmem_addr_sel);
    end
    checks++;
    if ({load_tag, load_data, load_valid, data_in_sel, set_dirty, clr_dirty} !== 6'b0) begin
      failures++;
      $display("FAIL reset_strobes got %b exp 000000", {load_tag, load_data, load_valid, data_in_sel, set_dirty, clr_dirty});
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_read_hit();
    int v;
    valid_m[5][2] = 1'b1; tag_m[5][2] = 7;
    do_access(5, 7, 1'b0, 1, 1, 1'b0, v);
    idle();
    checks++;
    if (v != 2) begin failures++; $display("FAIL read_hit_way got %0d exp 2", v); end
  endtask

  task automatic test_write_miss();
    int v;
    for (int w = 0; w < WAYS; w++) begin valid_m[6][w] = (w != 2); tag_m[6][w] = w + 1; end
    do_access(6, 9, 1'b1, 1, 5, 1'b0, v);
    idle();
    checks++;
    if (v != 2) begin failures++; $display("FAIL write_miss_victim got %0d exp 2", v); end
  endtask

  task automatic test_dirty_evict();
    int v;
    for (int w = 0; w < WAYS; w++) begin valid_m[7][w] = 1'b1; dirty_m[7][w] = 1'b1; tag_m[7][w] = w + 1; end
    do_access(7, 20, 1'b0, 3, 2, 1'b0, v);
    idle();
    checks++;
    if (v != 0) begin failures++; $display("FAIL evict_first got %0d exp 0", v); end
    do_access(7, 21, 1'b0, 2, 3, 1'b0, v);
    idle();
    checks++;
    if (v != 2) begin failures++; $display("FAIL evict_second got %0d exp 2", v); end
  endtask

  task automatic test_reset_mid_fill();
    int v;
    @(negedge clk);
    mem_read = 1'b1; mem_set = 5'd8; drive_vecs(8, 4);
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (pmem_read !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL prefill got pr=%b busy=%b exp 1 1", pmem_read, busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (pmem_read !== 1'b0 || busy !== 1'b0 || pmem_addr_sel !== 1'b1) begin
      failures++; $display("FAIL async_reset got pr=%b busy=%b asel=%b exp 0 0 1", pmem_read, busy, pmem_addr_sel);
    end
    @(negedge clk);
    rst = 1'b0; mem_read = 1'b0;
    model_reset();
    do_access(8, 4, 1'b0, 1, 2, 1'b0, v);
    idle();
    checks++;
    if (v != 0) begin failures++; $display("FAIL refill_way got %0d exp 0", v); end
  endtask

  task automatic test_idle_resp_and_drop();
    int v;
    @(negedge clk);
    pmem_resp = 1'b1;
    @(posedge clk);
    #1 pmem_resp = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
      failures++; $display("FAIL idle_resp got busy=%b pr=%b pw=%b exp 0", busy, pmem_read, pmem_write);
    end
    for (int w = 0; w < WAYS; w++) begin valid_m[9][w] = 1'b1; dirty_m[9][w] = 1'b1; tag_m[9][w] = w + 1; end
    do_access(9, 10, 1'b1, 3, 2, 1'b1, v);
    idle();
    checks++;
    if (v != 0) begin failures++; $display("FAIL drop_victim got %0d exp 0", v); end
  endtask

  task automatic test_random();
    int v;
    for (int n = 0; n < 200; n++)
      do_access($urandom_range(0, 3), $urandom_range(0, 5), 1'($urandom_range(0, 1)),
                $urandom_range(1, 4), $urandom_range(1, 4), 1'b0, v);
    idle();
  endtask

  task automatic test_back_to_back();
    int v, s, w;
    for (int n = 0; n < 20; n++) begin
      s = $urandom_range(0, 3);
      w = $urandom_range(0, WAYS - 1);
      if (valid_m[s][w]) do_access(s, tag_m[s][w], 1'($urandom_range(0, 1)), 1, 1, 1'b0, v);
    end
    idle();
  endtask

`ifdef L2_PERF_CNT_EN
  task automatic test_perf_counters();
    int v;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_reset();
    do_access(10, 1, 1'b0, 1, 2, 1'b0, v);
    idle();
    for (int w = 0; w < WAYS; w++) begin valid_m[11][w] = 1'b1; dirty_m[11][w] = 1'b1; tag_m[11][w] = w + 1; end
    do_access(11, 5, 1'b0, 2, 2, 1'b0, v);
    idle();
    do_access(10, 1, 1'b0, 1, 1, 1'b0, v);
    idle();
    @(negedge clk);
    checks++;
    if (hit_cnt !== 32'd3 || miss_cnt !== 32'd2 || wb_cnt !== 32'd1) begin
      failures++; $display("FAIL perf_cnt got h=%0d m=%0d w=%0d exp 3 2 1", hit_cnt, miss_cnt, wb_cnt);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_set = '0; pmem_resp = 1'b0;
    hit_vec = '0; valid_vec = '0; dirty_vec = '0;
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin tag_m[s][w] = 0; valid_m[s][w] = 1'b0; dirty_m[s][w] = 1'b0; end
    model_reset();
    test_reset();
    test_read_hit();
    test_write_miss();
    test_dirty_evict();
    test_reset_mid_fill();
    test_idle_resp_and_drop();
    test_random();
    test_back_to_back();
`ifdef L2_PERF_CNT_EN
    @(negedge clk);
    checks++;
    if (hit_cnt !== 32'(hits_m) || miss_cnt !== 32'(misses_m) || wb_cnt !== 32'(wbs_m)) begin
      failures++; $display("FAIL perf_model got h=%0d m=%0d w=%0d exp %0d %0d %0d", hit_cnt, miss_cnt, wb_cnt, hits_m, misses_m, wbs_m);
    end
    test_perf_counters();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
